// File: rtl/spi_core_temporary.sv
// -----------------------------------------------------------------------------
// spi_core_temporary
//
// Bit-level SPI datapath. Serialises an 8-bit transmit byte onto mosi and
// assembles an 8-bit receive byte from miso. The surrounding controller/baud
// generator supplies single-cycle edge qualifiers (flag_* for the receive path,
// flags_* for the transmit path), the mode configuration (cpol, cpha, lsbfe)
// and slave select. No SCLK is produced here; everything runs on PCLK.
//
// Optional feature macro: SPI_CORE_TEMPORARY_DONE_EN
//   When defined, adds output byte_done: a registered one-cycle pulse raised on
//   the shift event that wraps the bit counter from 7 back to 0, marking the
//   end of a complete byte.
// -----------------------------------------------------------------------------
module spi_core_temporary (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       receive_data,
    input  logic       send_data,
    input  logic [7:0] data_mosi,
    input  logic       ss,
    input  logic       cpha,
    input  logic       cpol,
    input  logic       miso,
    input  logic       lsbfe,
    input  logic       flags_low,
    input  logic       flags_high,
    input  logic       flag_low,
    input  logic       flag_high,
    output logic [7:0] data_miso,
`ifdef SPI_CORE_TEMPORARY_DONE_EN
    output logic       byte_done,
`endif
    output logic       mosi
);

    logic [7:0] r_shift_reg;
    logic [7:0] r_temp_reg;
    logic [2:0] r_count;
    logic       r_mosi;

    logic       w_mode_sel;
    logic       w_launch;
    logic       w_shift;
    logic       w_sample;
    logic [2:0] w_idx;

    // Modes 1 and 2 (cpha != cpol) swap which SCLK edge launches and which
    // edge samples/shifts, so the flag pairs are simply crossed over.
    assign w_mode_sel = cpha ^ cpol;
    assign w_launch   = w_mode_sel ? flags_low  : flags_high;
    assign w_shift    = w_mode_sel ? flags_high : flags_low;
    assign w_sample   = w_mode_sel ? flag_high  : flag_low;

    // Bit position addressed by both transmit and receive paths. It is derived
    // from the pre-update count, so an event coinciding with the shift still
    // uses the current bit.
    assign w_idx = lsbfe ? r_count : (3'd7 - r_count);

    // Transmit holding register: reloaded every cycle send_data is high,
    // regardless of slave select.
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values; blocking here would create order-
    // dependent races between the always_ff blocks.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_shift_reg <= 8'h00;
        end else if (send_data) begin
            r_shift_reg <= data_mosi;
        end
    end

    // Launch the addressed transmit bit onto mosi; mosi holds otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mosi <= 1'b0;
        end else if (!ss && w_launch) begin
            r_mosi <= r_shift_reg[w_idx];
        end
    end

    // Capture miso into the addressed receive bit; other bits are untouched
    // and the byte is deliberately not cleared between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_temp_reg <= 8'h00;
        end else if (!ss && w_sample) begin
            r_temp_reg[w_idx] <= miso;
        end
    end

    // Bit counter: cleared while deselected, advanced on each shift event,
    // wrapping naturally from 7 to 0 at the end of a byte.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count <= 3'd0;
        end else if (ss) begin
            r_count <= 3'd0;
        end else if (w_shift) begin
            r_count <= r_count + 3'd1;
        end
    end

`ifdef SPI_CORE_TEMPORARY_DONE_EN
    logic r_byte_done;

    // End-of-byte pulse: high for one cycle after the shift that wraps 7 -> 0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= !ss && w_shift && (r_count == 3'd7);
        end
    end

    assign byte_done = r_byte_done;
`endif

    assign mosi      = r_mosi;
    assign data_miso = receive_data ? r_temp_reg : 8'h00;

endmodule

// File: tb/tb_spi_core_temporary.sv
// -----------------------------------------------------------------------------
// tb_spi_core_temporary
//
// Directed bench for spi_core_temporary. Inputs change on the falling edge of
// PCLK and outputs are observed on the following falling edge, half a period
// after the rising edge that updated them. Expected values are hand-derived
// constants. Build with SPI_CORE_TEMPORARY_DONE_EN defined to also check
// byte_done.
// -----------------------------------------------------------------------------
module tb_spi_core_temporary;

    logic       PCLK;
    logic       PRESETn;
    logic       receive_data;
    logic       send_data;
    logic [7:0] data_mosi;
    logic       ss;
    logic       cpha;
    logic       cpol;
    logic       miso;
    logic       lsbfe;
    logic       flags_low;
    logic       flags_high;
    logic       flag_low;
    logic       flag_high;
    logic [7:0] data_miso;
    logic       mosi;
`ifdef SPI_CORE_TEMPORARY_DONE_EN
    logic       byte_done;
`endif

    int n_checks = 0;
    int n_errors = 0;

    spi_core_temporary dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .receive_data(receive_data),
        .send_data   (send_data),
        .data_mosi   (data_mosi),
        .ss          (ss),
        .cpha        (cpha),
        .cpol        (cpol),
        .miso        (miso),
        .lsbfe       (lsbfe),
        .flags_low   (flags_low),
        .flags_high  (flags_high),
        .flag_low    (flag_low),
        .flag_high   (flag_high),
        .data_miso   (data_miso),
`ifdef SPI_CORE_TEMPORARY_DONE_EN
        .byte_done   (byte_done),
`endif
        .mosi        (mosi)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle flag pulse: asserted on a falling edge, removed on the next,
    // so exactly one rising edge sees it and results are visible on return.
    task automatic pulse(input logic fs_lo, input logic fs_hi, input logic f_lo, input logic f_hi);
        @(negedge PCLK);
        flags_low  = fs_lo;
        flags_high = fs_hi;
        flag_low   = f_lo;
        flag_high  = f_hi;
        @(negedge PCLK);
        flags_low  = 1'b0;
        flags_high = 1'b0;
        flag_low   = 1'b0;
        flag_high  = 1'b0;
    endtask

    logic [7:0] exp_mosi;
    logic [7:0] miso_seq;

    initial begin
        // ---------------- reset with random inputs ----------------
        PRESETn      = 1'b0;
        receive_data = 1'b1;
        send_data    = 1'($urandom);
        data_mosi    = 8'($urandom);
        ss           = 1'b0;
        cpha         = 1'($urandom);
        cpol         = 1'($urandom);
        miso         = 1'($urandom);
        lsbfe        = 1'($urandom);
        flags_low    = 1'($urandom);
        flags_high   = 1'($urandom);
        flag_low     = 1'($urandom);
        flag_high    = 1'($urandom);
        repeat (4) @(negedge PCLK);
        check("rst_mosi", {7'd0, mosi}, 8'h00);
        check("rst_data_miso", data_miso, 8'h00);
        check("rst_count", {5'd0, dut.r_count}, 8'h00);

        // Release with quiet inputs: state must hold at reset values.
        send_data  = 1'b0;
        ss         = 1'b1;
        flags_low  = 1'b0;
        flags_high = 1'b0;
        flag_low   = 1'b0;
        flag_high  = 1'b0;
        PRESETn    = 1'b1;
        repeat (3) @(negedge PCLK);
        check("rel_mosi", {7'd0, mosi}, 8'h00);
        check("rel_data_miso", data_miso, 8'h00);
        check("rel_count", {5'd0, dut.r_count}, 8'h00);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
        check("rel_byte_done", {7'd0, byte_done}, 8'h00);
`endif

        // ---------------- MSB first, mode 0 ----------------
        cpha = 1'b0; cpol = 1'b0; lsbfe = 1'b0;
        data_mosi = 8'b1010_1010; send_data = 1'b1; ss = 1'b0;
        exp_mosi = 8'b1010_1010;   // first-to-last from bit 7 down
        miso_seq = 8'b1100_1100;   // first-to-last from bit 7 down
        @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b1);
            check($sformatf("m0_mosi%0d", i), {7'd0, mosi}, {7'd0, exp_mosi[7-i]});
            miso = miso_seq[7-i];
            pulse(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
            check($sformatf("m0_done%0d", i), {7'd0, byte_done}, {7'd0, (i == 7)});
`endif
        end
        check("m0_data_miso", data_miso, 8'b1100_1100);
        check("m0_count", {5'd0, dut.r_count}, 8'h00);

        // ---------------- LSB first, mode 3 ----------------
        cpha = 1'b1; cpol = 1'b1; lsbfe = 1'b1;
        data_mosi = 8'b1100_1100;
        exp_mosi = 8'b0011_0011;   // first-to-last from bit 7 down
        miso_seq = 8'b1010_1010;
        @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b1);
            check($sformatf("m3_mosi%0d", i), {7'd0, mosi}, {7'd0, exp_mosi[7-i]});
            miso = miso_seq[7-i];
            pulse(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
            check($sformatf("m3_done%0d", i), {7'd0, byte_done}, {7'd0, (i == 7)});
`endif
        end
        check("m3_temp", data_miso, 8'b0101_0101);

        // ---------------- mode_sel = 1 (mode 1), MSB first ----------------
        cpha = 1'b1; cpol = 1'b0; lsbfe = 1'b0;
        data_mosi = 8'hA5;
        exp_mosi = 8'b1010_0101;
        miso_seq = 8'b0101_1010;
        @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("m1_mosi%0d", i), {7'd0, mosi}, {7'd0, exp_mosi[7-i]});
            miso = miso_seq[7-i];
            pulse(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
            check($sformatf("m1_done%0d", i), {7'd0, byte_done}, {7'd0, (i == 7)});
`endif
        end
        check("m1_temp", data_miso, 8'h5A);

        // ---------------- deselected: all flags pulsing ----------------
        ss = 1'b1;
        data_mosi = 8'h00;
        miso = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b1, 1'b1, 1'b1);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
            check($sformatf("ss_done%0d", i), {7'd0, byte_done}, 8'h00);
`endif
        end
        check("ss_mosi", {7'd0, mosi}, 8'h01);
        check("ss_temp", data_miso, 8'h5A);
        check("ss_count", {5'd0, dut.r_count}, 8'h00);
        receive_data = 1'b0;
        @(negedge PCLK);
        check("rx_gate", data_miso, 8'h00);
        receive_data = 1'b1;

        // ---------------- abort after 3 bits, MSB first, mode 0 ----------------
        cpha = 1'b0; cpol = 1'b0; lsbfe = 1'b0;
        data_mosi = 8'h8F;
        exp_mosi = 8'b1000_0000;   // bits 7,6,5 of 8'h8F are 1,0,0
        miso = 1'b1;
        @(negedge PCLK);
        ss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b1);
            check($sformatf("ab_mosi%0d", i), {7'd0, mosi}, {7'd0, exp_mosi[7-i]});
            pulse(1'b1, 1'b0, 1'b1, 1'b0);
        end
        check("ab_count3", {5'd0, dut.r_count}, 8'h03);
        check("ab_partial", data_miso, 8'hFA);
        @(negedge PCLK);
        ss = 1'b1;
        @(negedge PCLK);
        check("ab_count_clr", {5'd0, dut.r_count}, 8'h00);
        check("ab_keep_temp", data_miso, 8'hFA);
        check("ab_hold_mosi", {7'd0, mosi}, 8'h00);
        ss = 1'b0;
        // Restarted byte must address bit 7 again: bit 7 of 8'h8F is 1.
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check("ab_relaunch", {7'd0, mosi}, 8'h01);
        miso = 1'b0;
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("ab_resample", data_miso, 8'h7A);
`ifdef SPI_CORE_TEMPORARY_DONE_EN
        check("ab_done", {7'd0, byte_done}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
